// File: rtl/link_tx_pkg.sv
// Shared definitions for the link transmitter: default widths and FSM state encodings.
package link_tx_pkg;

  localparam int unsigned NOC_DATA_WIDTH         = 8;
  localparam int unsigned NOC_CREDIT_DEPTH_WIDTH = 2;
  localparam int unsigned FLIT_CNT_WIDTH         = 16;

  typedef enum logic [1:0] {
    LTX_IDLE  = 2'd0,
    LTX_RUN   = 2'd1,
    LTX_DRAIN = 2'd2
  } ltx_state_e;

  // Downstream buffer depth, which is also the reset credit count.
  function automatic int unsigned credit_max(input int unsigned depth_w);
    return 32'd1 << depth_w;
  endfunction

endpackage

// File: rtl/link_tx_credit_counter.sv
// Saturating credit counter with a sticky overflow flag; shared with the router receive side.
module credit_counter #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned MAX   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o,
  output logic             err_o
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

  logic [WIDTH-1:0] r_count;
  logic             r_err;

  // Simultaneous inc and dec cancel; an inc at MAX is dropped and flagged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= MAX_VAL;
      r_err   <= 1'b0;
    end else if (inc_i && !dec_i) begin
      if (r_count == MAX_VAL) begin
        r_err <= 1'b1;
      end else begin
        r_count <= r_count + WIDTH'(1);
      end
    end else if (dec_i && !inc_i && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign count_o = r_count;
  assign zero_o  = (r_count == '0);
  assign err_o   = r_err;

endmodule

// File: rtl/link_tx.sv
// Credit-based link transmitter fed by a 1-cycle-latency FIFO read port.
// Optional flit statistics counter built when LINK_TX_STATS_EN is defined.
module link_tx
  import link_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = NOC_DATA_WIDTH,
  parameter int unsigned CREDIT_DEPTH_WIDTH = NOC_CREDIT_DEPTH_WIDTH,
  parameter int          ID                 = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic                          fifo_empty_i,
  input  logic [DATA_WIDTH-1:0]         fifo_data_i,
  output logic                          fifo_rd_en_o,
  output logic                          link_valid_o,
  output logic [DATA_WIDTH-1:0]         link_data_o,
  input  logic                          link_credit_i,
  output logic [CREDIT_DEPTH_WIDTH:0]   credits_o,
  output logic                          busy_o,
  output logic                          credit_err_o,
  output logic [FLIT_CNT_WIDTH-1:0]     flit_cnt_o
);

  localparam int unsigned CW         = CREDIT_DEPTH_WIDTH + 1;
  localparam int unsigned CREDIT_MAX = credit_max(CREDIT_DEPTH_WIDTH);

  ltx_state_e              r_state;
  logic                    r_rd_pend;
  logic                    r_link_valid;
  logic [DATA_WIDTH-1:0]   r_link_data;

  logic                    w_rd_en;
  logic                    w_credit_zero;
  logic                    w_credit_err;
  logic [CW-1:0]           w_credits;

  // ID only tags simulation banners; it has no hardware meaning.
  logic [31:0]             w_unused_id;
  assign w_unused_id = 32'(ID);

  // Reads are gated on a free downstream slot so neither FIFO can be violated.
  assign w_rd_en = (r_state == LTX_RUN) && en_i && !fifo_empty_i && !w_credit_zero;

  credit_counter #(
    .WIDTH (CW),
    .MAX   (CREDIT_MAX)
  ) u_credits (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (link_credit_i),
    .dec_i   (w_rd_en),
    .count_o (w_credits),
    .zero_o  (w_credit_zero),
    .err_o   (w_credit_err)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= LTX_IDLE;
      r_rd_pend    <= 1'b0;
      r_link_valid <= 1'b0;
      r_link_data  <= '0;
    end else begin
      r_rd_pend    <= w_rd_en;
      r_link_valid <= r_rd_pend;
      if (r_rd_pend) begin
        r_link_data <= fifo_data_i;
      end
      // DRAIN lets an already-issued read land before going idle.
      case (r_state)
        LTX_IDLE: begin
          if (en_i) r_state <= LTX_RUN;
        end
        LTX_RUN: begin
          if (!en_i) r_state <= r_rd_pend ? LTX_DRAIN : LTX_IDLE;
        end
        LTX_DRAIN: begin
          if (en_i)            r_state <= LTX_RUN;
          else if (!r_rd_pend) r_state <= LTX_IDLE;
        end
        default: r_state <= LTX_IDLE;
      endcase
    end
  end

`ifdef LINK_TX_STATS_EN
  logic [FLIT_CNT_WIDTH-1:0] r_flit_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_flit_cnt <= '0;
    end else if (r_link_valid && (r_flit_cnt != {FLIT_CNT_WIDTH{1'b1}})) begin
      r_flit_cnt <= r_flit_cnt + FLIT_CNT_WIDTH'(1);
    end
  end

  assign flit_cnt_o = r_flit_cnt;
`else
  assign flit_cnt_o = FLIT_CNT_WIDTH'(0);
`endif

  assign fifo_rd_en_o = w_rd_en;
  assign link_valid_o = r_link_valid;
  assign link_data_o  = r_link_data;
  assign credits_o    = w_credits;
  assign busy_o       = (r_state != LTX_IDLE) || r_rd_pend;
  assign credit_err_o = w_credit_err;

endmodule

// File: tb/tb_link_tx.sv
// Bench for link_tx: queue-based FIFO/link reference model with directed and random scenarios.
module tb_link_tx;

  localparam int CMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        link_credit;
  logic        fifo_rd_en;
  logic        link_valid;
  logic [7:0]  link_data;
  logic [2:0]  credits;
  logic        busy;
  logic        credit_err;
  logic [15:0] flit_cnt;

  always #5 clk = ~clk;

  link_tx #(.DATA_WIDTH(8), .CREDIT_DEPTH_WIDTH(2), .ID(0)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .fifo_empty_i  (fifo_empty),
    .fifo_data_i   (fifo_data),
    .fifo_rd_en_o  (fifo_rd_en),
    .link_valid_o  (link_valid),
    .link_data_o   (link_data),
    .link_credit_i (link_credit),
    .credits_o     (credits),
    .busy_o        (busy),
    .credit_err_o  (credit_err),
    .flit_cnt_o    (flit_cnt)
  );

  // Environment FIFO feeding the DUT: registered read data.
  logic [7:0] env_q[$];
  always @(posedge clk) begin
    if (fifo_rd_en === 1'b1 && env_q.size() != 0) fifo_data <= env_q.pop_front();
  end

  // Reference model: FIFO contents, flits in flight with their arrival cycle, credits.
  typedef struct { logic [7:0] data; int due; } flight_t;
  logic [7:0] m_fifo[$];
  flight_t    m_flight[$];
  int         m_state;   // 0 idle, 1 run, 2 drain
  int         m_credits;
  bit         m_err;
  int         m_cnt;
  bit         m_valid;
  logic [7:0] m_data;
  int         cyc;
  int         n_sent;
  int         n_total = 0;
  int         n_pass  = 0;

  task automatic push(input logic [7:0] d);
    env_q.push_back(d);
    m_fifo.push_back(d);
  endtask

  // One clock cycle: compare DUT to model, then advance the model across the edge.
  task automatic step(input bit chk);
    bit          exp_rd, pend, exp_busy;
    flight_t     f;
    logic [15:0] exp_cnt;
    fifo_empty = (env_q.size() == 0);
    #1;
    exp_rd   = (m_state == 1) && en && (m_fifo.size() != 0) && (m_credits != 0);
    pend     = (m_flight.size() != 0) && (m_flight[0].due == cyc + 1);
    exp_busy = (m_state != 0) || pend;
`ifdef LINK_TX_STATS_EN
    exp_cnt = 16'(m_cnt);
`else
    exp_cnt = 16'd0;
`endif
    if (link_valid === 1'b1) n_sent++;
    if (chk) begin
      n_total++; if (fifo_rd_en !== exp_rd) $display("FAIL rd_en cyc%0d: got %b want %b", cyc, fifo_rd_en, exp_rd); else n_pass++;
      n_total++; if (link_valid !== m_valid) $display("FAIL link_valid cyc%0d: got %b want %b", cyc, link_valid, m_valid); else n_pass++;
      n_total++; if (link_data !== m_data) $display("FAIL link_data cyc%0d: got %h want %h", cyc, link_data, m_data); else n_pass++;
      n_total++; if (credits !== 3'(m_credits)) $display("FAIL credits cyc%0d: got %0d want %0d", cyc, credits, m_credits); else n_pass++;
      n_total++; if (credit_err !== m_err) $display("FAIL credit_err cyc%0d: got %b want %b", cyc, credit_err, m_err); else n_pass++;
      n_total++; if (busy !== exp_busy) $display("FAIL busy cyc%0d: got %b want %b", cyc, busy, exp_busy); else n_pass++;
      n_total++; if (flit_cnt !== exp_cnt) $display("FAIL flit_cnt cyc%0d: got %0d want %0d", cyc, flit_cnt, exp_cnt); else n_pass++;
    end
    if (rst) begin
      if (exp_rd) void'(m_fifo.pop_front());
      m_flight.delete();
      m_state = 0; m_credits = CMAX; m_err = 0; m_cnt = 0; m_valid = 0; m_data = 8'h00;
    end else begin
      if (m_valid && m_cnt != 16'hFFFF) m_cnt++;
      if (pend) begin
        f = m_flight.pop_front();
        m_valid = 1; m_data = f.data;
      end else begin
        m_valid = 0;
      end
      if (exp_rd) begin
        f.data = m_fifo.pop_front();
        f.due  = cyc + 2;
        m_flight.push_back(f);
      end
      if (link_credit && !exp_rd) begin
        if (m_credits == CMAX) m_err = 1; else m_credits++;
      end else if (exp_rd && !link_credit) begin
        m_credits--;
      end
      case (m_state)
        0: if (en) m_state = 1;
        1: if (!en) m_state = pend ? 2 : 0;
        default: if (en) m_state = 1; else if (!pend) m_state = 0;
      endcase
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input bit chk);
    env_q.delete();
    m_fifo.delete();
    en = 0; link_credit = 0; rst = 1;
    step(chk);
    step(chk);
    rst = 0;
    n_sent = 0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    step(1'b1);
    n_total++; if (credits !== 3'd4 || link_valid !== 1'b0 || credit_err !== 1'b0)
      $display("FAIL reset_vals: got cr=%0d v=%b err=%b want cr=4 v=0 err=0", credits, link_valid, credit_err); else n_pass++;
    n_total++; if (busy !== 1'b0 || flit_cnt !== 16'd0)
      $display("FAIL reset_idle: got busy=%b cnt=%0d want busy=0 cnt=0", busy, flit_cnt); else n_pass++;
  endtask

  task automatic test_burst();
    do_reset(1'b1);
    push(8'hA1); push(8'hA2); push(8'hA3);
    en = 1;
    for (int i = 0; i < 8; i++) step(1'b1);
    n_total++; if (n_sent != 3) $display("FAIL burst_count: got %0d want 3", n_sent); else n_pass++;
    n_total++; if (credits !== 3'd1) $display("FAIL burst_credits: got %0d want 1", credits); else n_pass++;
    en = 0; step(1'b1);
  endtask

  task automatic test_credit_stall();
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) push(8'(8'h10 + i));
    en = 1;
    for (int i = 0; i < 10; i++) step(1'b1);
    n_total++; if (n_sent != 4) $display("FAIL stall_count: got %0d want 4", n_sent); else n_pass++;
    n_total++; if (credits !== 3'd0 || fifo_rd_en !== 1'b0)
      $display("FAIL stall_hold: got cr=%0d rd=%b want cr=0 rd=0", credits, fifo_rd_en); else n_pass++;
    link_credit = 1; step(1'b1); link_credit = 0;
    for (int i = 0; i < 5; i++) step(1'b1);
    n_total++; if (n_sent != 5) $display("FAIL stall_resume: got %0d want 5", n_sent); else n_pass++;
    en = 0; step(1'b1); step(1'b1);
  endtask

  task automatic test_same_cycle();
    do_reset(1'b1);
    push(8'h31); push(8'h32); push(8'h33);
    en = 1;
    for (int i = 0; i < 10 && m_credits != 1; i++) step(1'b1);
    push(8'h34); push(8'h35);
    link_credit = 1; step(1'b1); link_credit = 0;
    fifo_empty = (env_q.size() == 0);
    #1;
    n_total++; if (credits !== 3'd1) $display("FAIL same_cycle_credits: got %0d want 1", credits); else n_pass++;
    n_total++; if (fifo_rd_en !== 1'b1) $display("FAIL same_cycle_next_rd: got %b want 1", fifo_rd_en); else n_pass++;
    for (int i = 0; i < 4; i++) step(1'b1);
    en = 0; step(1'b1); step(1'b1);
  endtask

  task automatic test_drain();
    do_reset(1'b1);
    push(8'h5A); push(8'h5B);
    en = 1;
    step(1'b1);
    step(1'b1);
    en = 0;
    step(1'b1);
    n_total++; if (busy !== 1'b1 || fifo_rd_en !== 1'b0)
      $display("FAIL drain_state: got busy=%b rd=%b want busy=1 rd=0", busy, fifo_rd_en); else n_pass++;
    n_total++; if (link_valid !== 1'b1 || link_data !== 8'h5A)
      $display("FAIL drain_flit: got v=%b d=%h want v=1 d=5a", link_valid, link_data); else n_pass++;
    step(1'b1);
    n_total++; if (busy !== 1'b0) $display("FAIL drain_idle: got busy=%b want 0", busy); else n_pass++;
    step(1'b1);
  endtask

  task automatic test_credit_err();
    do_reset(1'b1);
    link_credit = 1; step(1'b1); link_credit = 0;
    for (int i = 0; i < 3; i++) step(1'b1);
    n_total++; if (credits !== 3'd4 || credit_err !== 1'b1)
      $display("FAIL err_sticky: got cr=%0d err=%b want cr=4 err=1", credits, credit_err); else n_pass++;
    do_reset(1'b1);
    step(1'b1);
    n_total++; if (credit_err !== 1'b0) $display("FAIL err_clear: got %b want 0", credit_err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) push(8'(8'hC0 + i));
    en = 1;
    for (int i = 0; i < 10 && !(m_valid && m_credits == 2); i++) step(1'b1);
    n_total++; if (link_valid !== 1'b1 || credits !== 3'd2)
      $display("FAIL mid_setup: got v=%b cr=%0d want v=1 cr=2", link_valid, credits); else n_pass++;
    rst = 1; step(1'b1); rst = 0; en = 0;
    n_total++; if (link_valid !== 1'b0 || credits !== 3'd4 || busy !== 1'b0 || flit_cnt !== 16'd0)
      $display("FAIL mid_reset: got v=%b cr=%0d busy=%b cnt=%0d want 0/4/0/0", link_valid, credits, busy, flit_cnt); else n_pass++;
    step(1'b1);
  endtask

  task automatic test_random();
    do_reset(1'b1);
    for (int i = 0; i < 400; i++) begin
      en          = ($urandom_range(0, 9) != 0);
      link_credit = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) != 0) push(8'($urandom));
      step(1'b1);
    end
    en = 0; link_credit = 0;
    for (int i = 0; i < 4; i++) step(1'b1);
  endtask

  initial begin
    rst = 1; en = 0; link_credit = 0; fifo_empty = 1; fifo_data = 8'h00;
    cyc = 0; n_sent = 0;
    m_state = 0; m_credits = CMAX; m_err = 0; m_cnt = 0; m_valid = 0; m_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_burst();
    test_credit_stall();
    test_same_cycle();
    test_drain();
    test_credit_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
